pcie_dl_tx_arbiter: RTL and testbench

Parametrised, packet-atomic transmit arbiter for the PCIe datalink layer. It merges S_COUNT AXI-Stream sources (for example the ack/nak DLLP, flow-control DLLP, TLP-retry and future vendor DLLP paths) onto the single stream toward the PHY logical layer. Arbitration mode is selectable: strict priority with starvation guard, or round robin. The block flushes cleanly when the link drops.

---
 rtl/pcie_dl_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pcie_dl_tx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_dl_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pcie_dl_tx_arbiter
//
// Packet-atomic transmit arbiter for the PCIe datalink layer. It merges
// S_COUNT AXI-Stream sources (ack/nak DLLP, flow-control DLLP, TLP retry,
// vendor DLLP, ...) onto the single stream toward the PHY logical layer.
//
// Handshake contract (both sides, strict AXI-Stream valid/ready):
//   a beat moves on a rising clock edge exactly when tvalid and tready are
//   both 1 in the cycle before that edge. A source may drop tvalid mid-packet;
//   the transfer then stalls with the grant held. Once m_axis_tvalid is 1,
//   the m_axis_* payload stays constant until the PHY takes it.
//
// Flow: IDLE picks a winner (one bubble cycle, no beat accepted), XFER
// forwards that source's packet through a one-entry output register until
// tlast is taken, and FLUSH sinks every source while the link is down.
// Mode: strict priority with a starvation guard, or round robin.
// state_o exposes the FSM state for debug and checkers.
// ---------------------------------------------------------------------------
module pcie_dl_tx_arbiter #(
    parameter int S_COUNT      = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 3,
    parameter int ROUND_ROBIN  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,

    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [S_COUNT-1:0]            s_axis_tready,

    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          m_axis_tready,

    input  logic                          link_up_i,
    output logic [S_COUNT-1:0]            grant_o,
    output logic                          starve_event_o,
    output logic [1:0]                    state_o
);

    localparam int PW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0]      LIMIT      = CW'(STARVE_LIMIT);
    localparam logic [S_COUNT-1:0] GRANT_ONE  = S_COUNT'(1);
    localparam bit                 USE_STARVE = (ROUND_ROBIN == 0) && (STARVE_LIMIT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [S_COUNT-1:0]   grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q [S_COUNT];
    logic [CW-1:0]        cnt_d [S_COUNT];
    logic                 starve_q, starve_d;

    logic                 out_ready;
    logic                 any_valid;
    logic                 beat_accept;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_last;

    logic [PW-1:0]        pri_idx, starve_idx, rr_idx, win_idx;
    logic                 pri_found, starve_hit, rr_found;
    logic [PW:0]          rr_pos;

    // The output register can take a new beat when empty or being drained.
    assign out_ready = ~m_axis_tvalid | m_axis_tready;
    assign any_valid = |s_axis_tvalid;

    assign grant_o        = grant_q;
    assign starve_event_o = starve_q;
    assign state_o        = state_q;

    // Source ready: only the granted port in XFER, every port while flushing.
    always_comb begin
        s_axis_tready = '0;
        case (state_q)
            ST_XFER:  s_axis_tready = grant_q & {S_COUNT{link_up_i & out_ready}};
            ST_FLUSH: s_axis_tready = '1;
            default:  s_axis_tready = '0;
        endcase
    end

    // Flushed beats are discarded, so only XFER handshakes count as accepted.
    assign beat_accept = (state_q == ST_XFER) && (|(s_axis_tvalid & s_axis_tready));

    // Payload mux for the granted source.
    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_user = '0;
        sel_last = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q[i]) begin
                sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_last = s_axis_tlast[i];
            end
        end
    end

    // Winner selection: fixed priority, starvation override, or rotating search.
    always_comb begin
        pri_idx    = '0;
        pri_found  = 1'b0;
        starve_idx = '0;
        starve_hit = 1'b0;
        rr_idx     = '0;
        rr_found   = 1'b0;
        rr_pos     = '0;
        win_idx    = '0;

        for (int i = 0; i < S_COUNT; i++) begin
            if (!pri_found && s_axis_tvalid[i]) begin
                pri_found = 1'b1;
                pri_idx   = PW'(i);
            end
        end

        // A starved port only overrides priority while it is still requesting.
        if (USE_STARVE) begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (!starve_hit && s_axis_tvalid[i] && (cnt_q[i] == LIMIT)) begin
                    starve_hit = 1'b1;
                    starve_idx = PW'(i);
                end
            end
        end

        for (int j = 0; j < S_COUNT; j++) begin
            rr_pos = {1'b0, ptr_q} + (PW+1)'(j);
            if (rr_pos >= (PW+1)'(S_COUNT)) begin
                rr_pos = rr_pos - (PW+1)'(S_COUNT);
            end
            if (!rr_found && s_axis_tvalid[rr_pos[PW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_pos[PW-1:0];
            end
        end

        if (ROUND_ROBIN != 0) begin
            win_idx = rr_idx;
        end else if (starve_hit) begin
            win_idx = starve_idx;
        end else begin
            win_idx = pri_idx;
        end
    end

    // FSM next state and grant; a link drop overrides every state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (!link_up_i) begin
            state_d = ST_FLUSH;
            grant_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        state_d = ST_XFER;
                        grant_d = GRANT_ONE << win_idx;
                    end
                end
                ST_XFER: begin
                    if (beat_accept && sel_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    // Arbitration bookkeeping: RR pointer, starvation counters, event pulse.
    always_comb begin
        ptr_d    = ptr_q;
        starve_d = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (!link_up_i) begin
            ptr_d = '0;
            for (int i = 0; i < S_COUNT; i++) begin
                cnt_d[i] = '0;
            end
        end else if ((state_q == ST_IDLE) && any_valid) begin
            if (ROUND_ROBIN != 0) begin
                ptr_d = (win_idx == PW'(S_COUNT - 1)) ? '0 : win_idx + PW'(1);
            end else if (USE_STARVE) begin
                starve_d = starve_hit;
                for (int i = 0; i < S_COUNT; i++) begin
                    if (PW'(i) == win_idx) begin
                        cnt_d[i] = '0;
                    end else if (s_axis_tvalid[i] && (cnt_q[i] != LIMIT)) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            starve_q <= 1'b0;
            for (int i = 0; i < S_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
            for (int i = 0; i < S_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // One-entry output register: load on accept, hold under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (!link_up_i) begin
            m_axis_tvalid <= 1'b0;
        end else if (beat_accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tuser  <= sel_user;
            m_axis_tlast  <= sel_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcie_dl_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcie_dl_tx_arbiter
//
// Two arbiters side by side: index 0 in priority mode (starve limit 2),
// index 1 in round-robin mode. A transaction-level reference model predicts
// grants, readies, output valid and the beat stream for each.
// ---------------------------------------------------------------------------
module tb_pcie_dl_tx_arbiter;

  localparam int S       = 3;
  localparam int DW      = 32;
  localparam int KW      = DW / 8;
  localparam int UW      = 3;
  localparam int PRI_LIM = 2;
  localparam int BW      = 1 + UW + KW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic link_up;
  logic [1:0] m_rdy;

  logic [S*DW-1:0] s_tdata  [2];
  logic [S*KW-1:0] s_tkeep  [2];
  logic [S-1:0]    s_tvalid [2];
  logic [S-1:0]    s_tlast  [2];
  logic [S*UW-1:0] s_tuser  [2];
  logic [S-1:0]    s_tready [2];
  logic [DW-1:0]   m_tdata  [2];
  logic [KW-1:0]   m_tkeep  [2];
  logic [UW-1:0]   m_tuser  [2];
  logic [1:0]      m_tvalid;
  logic [1:0]      m_tlast;
  logic [S-1:0]    grant    [2];
  logic [1:0]      starve_ev;
  logic [1:0]      st_dbg   [2];

  pcie_dl_tx_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .ROUND_ROBIN(0), .STARVE_LIMIT(PRI_LIM)
  ) dut_pri (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]), .m_axis_tready(m_rdy[0]),
    .link_up_i(link_up), .grant_o(grant[0]), .starve_event_o(starve_ev[0]),
    .state_o(st_dbg[0])
  );

  pcie_dl_tx_arbiter #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .ROUND_ROBIN(1), .STARVE_LIMIT(PRI_LIM)
  ) dut_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]), .m_axis_tready(m_rdy[1]),
    .link_up_i(link_up), .grant_o(grant[1]), .starve_event_o(starve_ev[1]),
    .state_o(st_dbg[1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit   busy_m [2];
  bit   ov_m   [2];
  bit   flush_m[2];
  bit   ev_m   [2];
  bit   new_m  [2];
  int   gnt_m  [2];
  int   ptr_m  [2];
  int   cnt_m  [2][S];
  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];
  bit   hold_chk[2];
  logic [BW-1:0] hold_val[2];
  int   obs_log0[$];
  int   obs_log1[$];
  logic [S-1:0] hs[2];

  // ---------------- stimulus knobs / generator state ----------------
  int rem[2][S];
  int p_start, p_drop, p_mr, p_link, min_len, max_len;
  int stall_cnt, link_dn_cnt;
  logic [S-1:0] en_mask[2];

  int exp_pri[6] = '{0, 0, 2, 0, 0, 2};
  int exp_rr3[4] = '{0, 1, 2, 0};
  int exp_rr2[3] = '{0, 2, 0};

  function automatic logic [BW-1:0] out_beat(input int k);
    return {m_tlast[k], m_tuser[k], m_tkeep[k], m_tdata[k]};
  endfunction

  function automatic logic [BW-1:0] in_beat(input int k, input int i);
    return {s_tlast[k][i], s_tuser[k][i*UW +: UW], s_tkeep[k][i*KW +: KW], s_tdata[k][i*DW +: DW]};
  endfunction

  function automatic int onehot_idx(input logic [S-1:0] g);
    int r;
    r = -1;
    if ($countones(g) == 1) begin
      for (int i = 0; i < S; i++) if (g[i]) r = i;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 0; ov_m[k] = 0; flush_m[k] = 0; ev_m[k] = 0; new_m[k] = 0;
      gnt_m[k] = 0; ptr_m[k] = 0; hold_chk[k] = 0; hs[k] = '0;
      for (int i = 0; i < S; i++) cnt_m[k][i] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic new_beat(input int k, input int i);
    s_tdata[k][i*DW +: DW] = $urandom;
    s_tkeep[k][i*KW +: KW] = KW'($urandom);
    s_tuser[k][i*UW +: UW] = UW'($urandom);
  endtask

  task automatic gen_reset();
    for (int k = 0; k < 2; k++) begin
      s_tvalid[k] = '0; s_tlast[k] = '0; s_tdata[k] = '0; s_tkeep[k] = '0; s_tuser[k] = '0;
      hs[k] = '0;
      for (int i = 0; i < S; i++) rem[k][i] = 0;
    end
  endtask

  task automatic set_knobs(input int ps, input int pd, input int pm, input int pl,
                           input int lmin, input int lmax);
    p_start = ps; p_drop = pd; p_mr = pm; p_link = pl; min_len = lmin; max_len = lmax;
  endtask

  // Compare one instance against the model for the current cycle, then
  // advance the model across the coming clock edge.
  task automatic model_step(input int k);
    logic [S-1:0]  v, r, exp_r, exp_g;
    logic [BW-1:0] ob, eb;
    bit mr, forced;
    int w, idx;
    v = s_tvalid[k];
    r = s_tready[k];
    mr = m_rdy[k];
    exp_g = busy_m[k] ? (S'(1) << gnt_m[k]) : '0;
    exp_r = flush_m[k] ? '1 : ((busy_m[k] && link_up && (!ov_m[k] || mr)) ? exp_g : '0);
    check_val($sformatf("grant%0d", k), 64'(grant[k]), 64'(exp_g));
    check_val($sformatf("s_tready%0d", k), 64'(r), 64'(exp_r));
    check_val($sformatf("m_tvalid%0d", k), 64'(m_tvalid[k]), 64'(ov_m[k]));
    check_val($sformatf("starve%0d", k), 64'(starve_ev[k]), 64'(ev_m[k]));
    if (new_m[k]) begin
      if (k == 0) obs_log0.push_back(onehot_idx(grant[k]));
      else        obs_log1.push_back(onehot_idx(grant[k]));
      new_m[k] = 0;
    end
    ob = out_beat(k);
    if (hold_chk[k] && m_tvalid[k]) check_val($sformatf("hold%0d", k), 64'(ob), 64'(hold_val[k]));
    hold_chk[k] = m_tvalid[k] && !mr;
    hold_val[k] = ob;
    if (m_tvalid[k] && mr) begin
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check_val($sformatf("out_extra%0d", k), 64'd1, 64'd0);
      end else begin
        eb = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_val($sformatf("out_beat%0d", k), 64'(ob), 64'(eb));
      end
    end
    hs[k] = v & r;

    ev_m[k] = 0;
    if (!link_up) begin
      flush_m[k] = 1; busy_m[k] = 0; ov_m[k] = 0; ptr_m[k] = 0;
      for (int i = 0; i < S; i++) cnt_m[k][i] = 0;
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
    end else if (flush_m[k]) begin
      flush_m[k] = 0;
    end else if (busy_m[k]) begin
      if (v[gnt_m[k]] && (!ov_m[k] || mr)) begin
        if (k == 0) exp_q0.push_back(in_beat(k, gnt_m[k]));
        else        exp_q1.push_back(in_beat(k, gnt_m[k]));
        ov_m[k] = 1;
        if (s_tlast[k][gnt_m[k]]) busy_m[k] = 0;
      end else if (mr) begin
        ov_m[k] = 0;
      end
    end else begin
      if (mr) ov_m[k] = 0;
      if (|v) begin
        w = -1;
        forced = 0;
        if (k == 0) begin
          for (int i = 0; i < S; i++)
            if (w < 0 && v[i] && cnt_m[k][i] >= PRI_LIM) begin w = i; forced = 1; end
          for (int i = 0; i < S; i++)
            if (w < 0 && v[i]) w = i;
          for (int i = 0; i < S; i++) begin
            if (i == w) cnt_m[k][i] = 0;
            else if (v[i] && cnt_m[k][i] < PRI_LIM) cnt_m[k][i]++;
          end
        end else begin
          for (int j = 0; j < S; j++) begin
            idx = (ptr_m[k] + j) % S;
            if (w < 0 && v[idx]) w = idx;
          end
          ptr_m[k] = (w + 1) % S;
        end
        busy_m[k] = 1;
        gnt_m[k] = w;
        ev_m[k] = forced;
        new_m[k] = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_next();
    if (link_dn_cnt > 0) begin
      link_up = 0;
      link_dn_cnt--;
    end else begin
      link_up = ($urandom_range(99) >= p_link);
    end
    for (int k = 0; k < 2; k++) m_rdy[k] = (stall_cnt > 0) ? 1'b0 : ($urandom_range(99) < p_mr);
    if (stall_cnt > 0) stall_cnt--;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < S; i++) begin
        if (hs[k][i]) begin
          rem[k][i]--;
          if (rem[k][i] > 0) new_beat(k, i);
        end
        if (rem[k][i] == 0 && en_mask[k][i] && $urandom_range(99) < p_start) begin
          rem[k][i] = $urandom_range(max_len, min_len);
          new_beat(k, i);
        end
        s_tvalid[k][i] = (rem[k][i] > 0) && ($urandom_range(99) >= p_drop);
        s_tlast[k][i]  = (rem[k][i] == 1);
      end
      hs[k] = '0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      drive_next();
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s_grant%0d", tag, k), 64'(grant[k]), 64'd0);
      check_val($sformatf("%s_m_tvalid%0d", tag, k), 64'(m_tvalid[k]), 64'd0);
      check_val($sformatf("%s_m_tlast%0d", tag, k), 64'(m_tlast[k]), 64'd0);
      check_val($sformatf("%s_m_tdata%0d", tag, k), 64'(m_tdata[k]), 64'd0);
      check_val($sformatf("%s_m_tkeep%0d", tag, k), 64'(m_tkeep[k]), 64'd0);
      check_val($sformatf("%s_m_tuser%0d", tag, k), 64'(m_tuser[k]), 64'd0);
      check_val($sformatf("%s_s_tready%0d", tag, k), 64'(s_tready[k]), 64'd0);
      check_val($sformatf("%s_starve%0d", tag, k), 64'(starve_ev[k]), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    gen_reset();
    link_up = 1;
    m_rdy = 2'b11;
    stall_cnt = 0;
    link_dn_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    drive_next();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0;
    en_mask[0] = '1;
    en_mask[1] = '1;
    set_knobs(100, 0, 100, 0, 3, 3);

    // Single requester on port 1, 3-beat packets, PHY always ready.
    en_mask[0] = 3'b010; en_mask[1] = 3'b010;
    do_reset();
    run(20);

    // Contention with 1-beat packets: priority (ports 0,2) and RR (all ports).
    set_knobs(100, 0, 100, 0, 1, 1);
    en_mask[0] = 3'b101; en_mask[1] = 3'b111;
    do_reset();
    obs_log0.delete(); obs_log1.delete();
    run(16);
    check_val("pri_grant_count", 64'(obs_log0.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++)
      if (i < obs_log0.size()) check_val($sformatf("pri_order%0d", i), 64'(obs_log0[i]), 64'(exp_pri[i]));
    check_val("rr3_grant_count", 64'(obs_log1.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < obs_log1.size()) check_val($sformatf("rr3_order%0d", i), 64'(obs_log1[i]), 64'(exp_rr3[i]));

    // Round robin with only ports 0 and 2 requesting.
    en_mask[1] = 3'b101;
    do_reset();
    obs_log1.delete();
    run(12);
    check_val("rr2_grant_count", 64'(obs_log1.size() >= 3), 64'd1);
    for (int i = 0; i < 3; i++)
      if (i < obs_log1.size()) check_val($sformatf("rr2_order%0d", i), 64'(obs_log1[i]), 64'(exp_rr2[i]));

    // Backpressure: PHY stalls for 4 cycles mid-packet.
    set_knobs(100, 0, 100, 0, 5, 5);
    en_mask[0] = 3'b001; en_mask[1] = 3'b001;
    do_reset();
    run(3);
    stall_cnt = 4;
    run(14);

    // Link drop during a 5-beat packet, then recovery.
    do_reset();
    run(3);
    link_dn_cnt = 1;
    run(14);

    // Randomised traffic: gaps, mid-packet valid drops, backpressure, link drops.
    set_knobs(30, 15, 70, 2, 1, 4);
    en_mask[0] = '1; en_mask[1] = '1;
    do_reset();
    run(3000);

    // Asynchronous reset mid-transfer.
    set_knobs(100, 0, 100, 0, 5, 5);
    do_reset();
    run(4);
    #2;
    rst_n = 0;
    #1;
    check_zero("async");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
